// File: rtl/tblock_warp_allocator.sv
// tblock_warp_allocator
//   Allocates each thread block onto 1..MaxWarpsPerTblock warp slots in a
//   single cycle, holds the per-warp block data, strobes the per-warp ITS
//   init, and reports a block as done once every member warp has finished.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   alloc_*_i / alloc_ready_o     allocation request; ready is independent of valid
//   free_warps_o                  number of unoccupied warp slots
//   warp_init_o / warp_init_pc_o  per-warp init strobe and start PC for the ITS units
//   warp_occupied_o               per-warp occupied flags
//   warp_dp_addr_o, warp_tblock_idx_o, warp_sub_idx_o   per-warp block data
//   warp_finished_i, ib_all_instr_finished_i            per-warp completion status
//   tblock_done_valid_o / tblock_done_ready_i / tblock_done_id_o   completion handshake
module tblock_warp_allocator #(
  parameter int unsigned PcWidth           = 32,
  parameter int unsigned NumWarps          = 32,
  parameter int unsigned MaxWarpsPerTblock = 4,
  parameter int unsigned TblockIdxBits     = 4,
  parameter int unsigned TgroupIdBits      = 4,
  parameter int unsigned AddressWidth      = 32,
  localparam int unsigned WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int unsigned WcntWidth = $clog2(MaxWarpsPerTblock + 1),
  localparam int unsigned WsubWidth = (MaxWarpsPerTblock > 1) ? $clog2(MaxWarpsPerTblock) : 1,
  localparam int unsigned FreeWidth = $clog2(NumWarps + 1)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       alloc_valid_i,
  output logic                                       alloc_ready_o,
  input  logic [WcntWidth-1:0]                       alloc_num_warps_i,
  input  logic [PcWidth-1:0]                         alloc_pc_i,
  input  logic [AddressWidth-1:0]                    alloc_dp_addr_i,
  input  logic [TblockIdxBits-1:0]                   alloc_tblock_idx_i,
  input  logic [TgroupIdBits-1:0]                    alloc_tgroup_id_i,
  output logic [FreeWidth-1:0]                       free_warps_o,
  output logic [NumWarps-1:0]                        warp_init_o,
  output logic [PcWidth-1:0]                         warp_init_pc_o,
  output logic [NumWarps-1:0]                        warp_occupied_o,
  output logic [NumWarps-1:0][AddressWidth-1:0]      warp_dp_addr_o,
  output logic [NumWarps-1:0][TblockIdxBits-1:0]     warp_tblock_idx_o,
  output logic [NumWarps-1:0][WsubWidth-1:0]         warp_sub_idx_o,
  input  logic [NumWarps-1:0]                        warp_finished_i,
  input  logic [NumWarps-1:0]                        ib_all_instr_finished_i,
  output logic                                       tblock_done_valid_o,
  input  logic                                       tblock_done_ready_i,
  output logic [TgroupIdBits-1:0]                    tblock_done_id_o
);

  logic [NumWarps-1:0]                    occupied_q, occupied_d;
  logic [NumWarps-1:0]                    leader_q, leader_d;
  logic [NumWarps-1:0][NumWarps-1:0]      mask_q, mask_d;
  logic [NumWarps-1:0][AddressWidth-1:0]  dp_addr_q, dp_addr_d;
  logic [NumWarps-1:0][TblockIdxBits-1:0] tblock_idx_q, tblock_idx_d;
  logic [NumWarps-1:0][TgroupIdBits-1:0]  tgroup_id_q, tgroup_id_d;
  logic [NumWarps-1:0][WsubWidth-1:0]     sub_idx_q, sub_idx_d;
  logic [WidWidth-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [WidWidth-1:0]                    gnt_q, gnt_d;
  logic                                   lock_q, lock_d;

  logic [NumWarps-1:0]                    sel;
  logic [NumWarps-1:0][WsubWidth-1:0]     sel_sub;
  logic [FreeWidth-1:0]                   free_cnt;
  logic [NumWarps-1:0]                    fin_both;
  logic [NumWarps-1:0]                    cand;
  logic                                   arb_found;
  logic [WidWidth-1:0]                    arb_idx;
  logic [WidWidth-1:0]                    done_gnt;
  logic                                   alloc_fire;
  logic                                   done_fire;
  logic                                   overlap_err;

  // Free count and lowest-N free warp selection, both from registered
  // occupancy so warps released this cycle cannot be reused until the next.
  always_comb begin
    int unsigned taken;
    free_cnt = '0;
    sel      = '0;
    sel_sub  = '0;
    taken    = 0;
    for (int w = 0; w < NumWarps; w++) begin
      if (!occupied_q[w]) begin
        free_cnt = free_cnt + FreeWidth'(1);
        if (taken < 32'(alloc_num_warps_i)) begin
          sel[w]     = 1'b1;
          sel_sub[w] = WsubWidth'(taken);
          taken      = taken + 1;
        end
      end
    end
  end

  assign alloc_ready_o = rst_ni && (alloc_num_warps_i != '0)
                       && (32'(alloc_num_warps_i) <= MaxWarpsPerTblock)
                       && (32'(free_cnt) >= 32'(alloc_num_warps_i));
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  // A leader is a candidate once every warp in its mask is fully drained;
  // bits outside the mask are don't-care.
  assign fin_both = warp_finished_i & ib_all_instr_finished_i;

  always_comb begin
    int unsigned j;
    cand      = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    for (int w = 0; w < NumWarps; w++) begin
      cand[w] = occupied_q[w] && leader_q[w] && ((mask_q[w] & ~fin_both) == '0);
    end
    for (int i = 0; i < NumWarps; i++) begin
      j = 32'(rr_ptr_q) + i;
      if (j >= NumWarps) j = j - NumWarps;
      if (!arb_found && cand[j]) begin
        arb_found = 1'b1;
        arb_idx   = WidWidth'(j);
      end
    end
  end

  // Once presented, the grant is frozen until accepted.
  assign done_gnt            = lock_q ? gnt_q : arb_idx;
  assign tblock_done_valid_o = lock_q || arb_found;
  assign tblock_done_id_o    = tgroup_id_q[done_gnt];
  assign done_fire           = tblock_done_valid_o && tblock_done_ready_i;

  always_comb begin
    logic first;
    occupied_d   = occupied_q;
    leader_d     = leader_q;
    mask_d       = mask_q;
    dp_addr_d    = dp_addr_q;
    tblock_idx_d = tblock_idx_q;
    tgroup_id_d  = tgroup_id_q;
    sub_idx_d    = sub_idx_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    lock_d       = lock_q;
    first        = 1'b1;
    if (done_fire) begin
      occupied_d       = occupied_q & ~mask_q[done_gnt];
      leader_d         = leader_q & ~mask_q[done_gnt];
      mask_d[done_gnt] = '0;
      lock_d           = 1'b0;
      rr_ptr_d         = (32'(done_gnt) == NumWarps - 1) ? '0 : done_gnt + WidWidth'(1);
    end else if (tblock_done_valid_o) begin
      lock_d = 1'b1;
      gnt_d  = done_gnt;
    end
    // Selected warps are all unoccupied, so they never collide with the
    // warps being released above.
    if (alloc_fire) begin
      for (int w = 0; w < NumWarps; w++) begin
        if (sel[w]) begin
          occupied_d[w]   = 1'b1;
          leader_d[w]     = first;
          mask_d[w]       = first ? sel : '0;
          dp_addr_d[w]    = alloc_dp_addr_i;
          tblock_idx_d[w] = alloc_tblock_idx_i;
          tgroup_id_d[w]  = alloc_tgroup_id_i;
          sub_idx_d[w]    = sel_sub[w];
          first           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupied_q   <= '0;
      leader_q     <= '0;
      mask_q       <= '0;
      dp_addr_q    <= '0;
      tblock_idx_q <= '0;
      tgroup_id_q  <= '0;
      sub_idx_q    <= '0;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      lock_q       <= 1'b0;
    end else begin
      occupied_q   <= occupied_d;
      leader_q     <= leader_d;
      mask_q       <= mask_d;
      dp_addr_q    <= dp_addr_d;
      tblock_idx_q <= tblock_idx_d;
      tgroup_id_q  <= tgroup_id_d;
      sub_idx_q    <= sub_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      lock_q       <= lock_d;
    end
  end

  assign free_warps_o      = free_cnt;
  assign warp_init_o       = alloc_fire ? sel : '0;
  assign warp_init_pc_o    = alloc_pc_i;
  assign warp_occupied_o   = occupied_q;
  assign warp_dp_addr_o    = dp_addr_q;
  assign warp_tblock_idx_o = tblock_idx_q;
  assign warp_sub_idx_o    = sub_idx_q;

  always_comb begin
    overlap_err = 1'b0;
    for (int a = 0; a < NumWarps; a++) begin
      for (int b = a + 1; b < NumWarps; b++) begin
        if (leader_q[a] && leader_q[b] && ((mask_q[a] & mask_q[b]) != '0)) overlap_err = 1'b1;
      end
    end
  end

  a_no_overlap: assert property (@(posedge clk_i) disable iff (!rst_ni) !overlap_err);
  a_legal_num:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                  alloc_fire |-> (alloc_num_warps_i != '0 && 32'(alloc_num_warps_i) <= MaxWarpsPerTblock));
  a_cand_occ:   assert property (@(posedge clk_i) disable iff (!rst_ni) (cand & ~occupied_q) == '0);

endmodule

// File: tb/tb_tblock_warp_allocator.sv
module tb_tblock_warp_allocator;
  localparam int NW = 8;
  localparam int MX = 4;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             alloc_valid_i = 1'b0;
  logic             alloc_ready_o;
  logic [2:0]       alloc_num_warps_i = '0;
  logic [31:0]      alloc_pc_i = '0;
  logic [31:0]      alloc_dp_addr_i = '0;
  logic [3:0]       alloc_tblock_idx_i = '0;
  logic [3:0]       alloc_tgroup_id_i = '0;
  logic [3:0]       free_warps_o;
  logic [7:0]       warp_init_o;
  logic [31:0]      warp_init_pc_o;
  logic [7:0]       warp_occupied_o;
  logic [7:0][31:0] warp_dp_addr_o;
  logic [7:0][3:0]  warp_tblock_idx_o;
  logic [7:0][1:0]  warp_sub_idx_o;
  logic [7:0]       warp_finished_i = '0;
  logic [7:0]       ib_all_instr_finished_i = '0;
  logic             tblock_done_valid_o;
  logic             tblock_done_ready_i = 1'b0;
  logic [3:0]       tblock_done_id_o;

  always #5 clk = ~clk;

  tblock_warp_allocator #(.NumWarps(NW), .MaxWarpsPerTblock(MX)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_num_warps_i(alloc_num_warps_i), .alloc_pc_i(alloc_pc_i),
    .alloc_dp_addr_i(alloc_dp_addr_i), .alloc_tblock_idx_i(alloc_tblock_idx_i),
    .alloc_tgroup_id_i(alloc_tgroup_id_i), .free_warps_o(free_warps_o),
    .warp_init_o(warp_init_o), .warp_init_pc_o(warp_init_pc_o),
    .warp_occupied_o(warp_occupied_o), .warp_dp_addr_o(warp_dp_addr_o),
    .warp_tblock_idx_o(warp_tblock_idx_o), .warp_sub_idx_o(warp_sub_idx_o),
    .warp_finished_i(warp_finished_i), .ib_all_instr_finished_i(ib_all_instr_finished_i),
    .tblock_done_valid_o(tblock_done_valid_o), .tblock_done_ready_i(tblock_done_ready_i),
    .tblock_done_id_o(tblock_done_id_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: a set of blocks keyed by leader warp, each with a member set.
  logic [7:0]       m_occ;
  logic [7:0]       m_lead;
  logic [7:0]       m_mask [NW];
  logic [7:0][31:0] m_dp;
  logic [7:0][3:0]  m_tidx;
  logic [7:0][3:0]  m_tg;
  logic [7:0][1:0]  m_sub;
  int               m_ptr;
  bit               m_lock;
  int               m_lgnt;

  logic [7:0] e_sel;
  bit         e_ready;
  bit         e_dv;
  int         e_g;
  int         e_free;

  task automatic model_reset();
    m_occ = '0; m_lead = '0; m_dp = '0; m_tidx = '0; m_tg = '0; m_sub = '0;
    for (int i = 0; i < NW; i++) m_mask[i] = '0;
    m_ptr = 0; m_lock = 0; m_lgnt = 0;
  endtask

  task automatic predict();
    int n, k, j;
    logic [7:0] fb;
    n = int'(alloc_num_warps_i);
    e_free = 0;
    for (int w = 0; w < NW; w++) if (!m_occ[w]) e_free++;
    e_ready = rst_ni && n >= 1 && n <= MX && e_free >= n;
    e_sel = '0; k = 0;
    for (int w = 0; w < NW; w++) if (!m_occ[w] && k < n) begin e_sel[w] = 1'b1; k++; end
    fb = warp_finished_i & ib_all_instr_finished_i;
    e_dv = 0; e_g = 0;
    if (m_lock) begin
      e_dv = 1; e_g = m_lgnt;
    end else begin
      for (int i = 0; i < NW; i++) begin
        j = (m_ptr + i) % NW;
        if (!e_dv && m_lead[j] && ((m_mask[j] & ~fb) == 8'h00)) begin e_dv = 1; e_g = j; end
      end
    end
  endtask

  task automatic compare();
    check_eq("alloc_ready", alloc_ready_o, e_ready);
    check_eq("free_warps", free_warps_o, e_free);
    check_eq("warp_init", warp_init_o, (alloc_valid_i && e_ready) ? e_sel : 8'h00);
    check_eq("init_pc", warp_init_pc_o, alloc_pc_i);
    check_eq("occupied", warp_occupied_o, m_occ);
    check_eq("dp_addr", warp_dp_addr_o, m_dp);
    check_eq("tblock_idx", warp_tblock_idx_o, m_tidx);
    check_eq("sub_idx", warp_sub_idx_o, m_sub);
    check_eq("done_valid", tblock_done_valid_o, e_dv);
    if (e_dv) check_eq("done_id", tblock_done_id_o, m_tg[e_g]);
  endtask

  task automatic commit();
    int k;
    bit first;
    if (e_dv && tblock_done_ready_i) begin
      m_occ = m_occ & ~m_mask[e_g];
      m_lead[e_g] = 1'b0;
      m_ptr = (e_g + 1) % NW;
      m_lock = 0;
    end else if (e_dv) begin
      m_lock = 1; m_lgnt = e_g;
    end
    if (alloc_valid_i && e_ready) begin
      k = 0; first = 1;
      for (int w = 0; w < NW; w++) begin
        if (e_sel[w]) begin
          m_occ[w] = 1'b1;
          m_lead[w] = first;
          if (first) m_mask[w] = e_sel;
          m_dp[w] = alloc_dp_addr_i;
          m_tidx[w] = alloc_tblock_idx_i;
          m_tg[w] = alloc_tgroup_id_i;
          m_sub[w] = 2'(k);
          k++; first = 0;
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    if (!rst_ni) model_reset();
    predict();
    compare();
    @(posedge clk);
    if (rst_ni) commit(); else model_reset();
    @(negedge clk);
  endtask

  task automatic req(input bit v, input int n, input logic [3:0] tg);
    alloc_valid_i      = v;
    alloc_num_warps_i  = 3'(n);
    alloc_tgroup_id_i  = tg;
    alloc_pc_i         = $urandom;
    alloc_dp_addr_i    = $urandom;
    alloc_tblock_idx_i = 4'($urandom_range(0, 15));
  endtask

  task automatic status(input logic [7:0] fin, input logic [7:0] ib, input bit rdy);
    warp_finished_i = fin; ib_all_instr_finished_i = ib; tblock_done_ready_i = rdy;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; cycle(); rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // reset state with a pending request
    req(1, 3, 4'h1); status(8'h00, 8'h00, 1'b0);
    #1;
    check_eq("rst_free", free_warps_o, 4'd8);
    check_eq("rst_ready", alloc_ready_o, 1'b0);
    check_eq("rst_occ", warp_occupied_o, 8'h00);
    cycle();
    rst_ni = 1'b1;

    // N=3 on empty unit
    req(1, 3, 4'h1); #1;
    check_eq("n3_init", warp_init_o, 8'b0000_0111);
    cycle();
    req(0, 0, 4'h0); #1;
    check_eq("n3_sub", warp_sub_idx_o[2:0], 6'b10_01_00);
    check_eq("n3_free", free_warps_o, 4'd5);
    cycle();

    // occupy 0,2,4 then allocate a non-contiguous block
    do_reset();
    for (int i = 0; i < 5; i++) begin req(1, 1, 4'(i)); cycle(); end
    req(0, 0, 4'h0); status(8'b0000_1010, 8'hFF, 1'b1); cycle(); cycle();
    status(8'h00, 8'h00, 1'b0); #1;
    check_eq("gap_occ", warp_occupied_o, 8'b0001_0101);
    req(1, 4, 4'h9); #1;
    check_eq("gap_init", warp_init_o, 8'b0110_1010);
    cycle();
    req(1, 2, 4'h3); #1;
    check_eq("gap_sub", warp_sub_idx_o, 16'h3840);
    check_eq("gap_ready", alloc_ready_o, 1'b0);
    cycle();

    // two-warp block finishing one warp at a time, then a held handshake
    do_reset();
    req(1, 2, 4'hA); cycle();
    req(0, 0, 4'h0); status(8'h01, 8'hFF, 1'b0); #1;
    check_eq("part_valid", tblock_done_valid_o, 1'b0);
    cycle();
    status(8'h03, 8'h03, 1'b0); #1;
    check_eq("hold_id0", tblock_done_id_o, 4'hA);
    cycle();
    status(8'h00, 8'h00, 1'b0); cycle(); cycle();
    status(8'h00, 8'h00, 1'b1); #1;
    check_eq("hold_id3", tblock_done_id_o, 4'hA);
    check_eq("hold_valid3", tblock_done_valid_o, 1'b1);
    cycle();
    status(8'h00, 8'h00, 1'b0); #1;
    check_eq("freed_free", free_warps_o, 4'd8);
    cycle();

    // round-robin between leaders 0 and 4
    do_reset();
    req(1, 4, 4'h1); cycle(); req(1, 4, 4'h2); cycle();
    req(0, 0, 4'h0); status(8'hFF, 8'hFF, 1'b1); #1;
    check_eq("rr_first", tblock_done_id_o, 4'h1); cycle(); #1;
    check_eq("rr_second", tblock_done_id_o, 4'h2); cycle();
    status(8'h00, 8'h00, 1'b0);
    req(1, 4, 4'h3); cycle(); req(1, 4, 4'h4); cycle();
    req(0, 0, 4'h0); status(8'h0F, 8'hFF, 1'b1); cycle();
    status(8'h00, 8'h00, 1'b0); req(1, 4, 4'h5); cycle();
    req(0, 0, 4'h0); status(8'hFF, 8'hFF, 1'b1); #1;
    check_eq("rot_first", tblock_done_id_o, 4'h4); cycle(); #1;
    check_eq("rot_second", tblock_done_id_o, 4'h5); cycle();

    // free and allocate on a full unit in the same cycle
    status(8'h00, 8'h00, 1'b0);
    req(1, 4, 4'h6); cycle(); req(1, 4, 4'h7); cycle();
    req(1, 2, 4'h8); status(8'hFF, 8'hFF, 1'b1); #1;
    check_eq("full_ready", alloc_ready_o, 1'b0);
    cycle();
    status(8'h00, 8'h00, 1'b0); #1;
    check_eq("refill_ready", alloc_ready_o, 1'b1);
    check_eq("refill_init", warp_init_o, 8'b0011_0000);
    cycle();

    // illegal sizes and reset during a pending handshake
    do_reset();
    req(1, 0, 4'h1); #1; check_eq("n0_ready", alloc_ready_o, 1'b0); cycle();
    req(1, 5, 4'h1); #1; check_eq("n5_ready", alloc_ready_o, 1'b0); cycle();
    req(1, 2, 4'hC); cycle();
    req(1, 3, 4'hD); status(8'h03, 8'hFF, 1'b0); cycle();
    rst_ni = 1'b0; #1;
    check_eq("mid_occ", warp_occupied_o, 8'h00);
    check_eq("mid_free", free_warps_o, 4'd8);
    check_eq("mid_valid", tblock_done_valid_o, 1'b0);
    check_eq("mid_init", warp_init_o, 8'h00);
    check_eq("mid_dp", warp_dp_addr_o, 256'h0);
    cycle();
    rst_ni = 1'b1;
    status(8'h03, 8'hFF, 1'b1); #1;
    check_eq("post_rst_valid", tblock_done_valid_o, 1'b0);
    cycle();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_ni = ($urandom_range(0, 299) != 0);
      req($urandom_range(0, 9) < 7, $urandom_range(0, 5), 4'($urandom_range(0, 15)));
      status(8'($urandom | $urandom), 8'($urandom | $urandom | $urandom), 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
